alarm_clock_ctrl: RTL

- Timekeeping and alarm controller for the reloj-despertador system. Sits between the button/switch PIOs and the six seven-segment PIOs plus the LED PIO.
- Generates a 1 Hz tick and keeps BCD hh:mm:ss in 24 h format.
- A mode FSM, driven by button presses, sets the time and the alarm.
- Sequences the alarm ring: start on time match, stop on timeout, dismiss or disable.

---
 rtl/alarm_clock_ctrl.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_clock_ctrl.sv
// alarm_clock_ctrl: timekeeping and alarm controller for the alarm clock.
// A prescaler produces a one-cycle tick every TICKS_PER_SEC clocks. The
// controller keeps BCD hh:mm:ss (24 h) plus a BCD alarm hh:mm. A button-driven
// mode FSM (RUN -> SET_H -> SET_M -> SET_AH -> SET_AM -> RUN) edits them, and
// the alarm ring is started on a time match and stopped on timeout, dismiss,
// mode or when the alarm is disabled.
// Ports:
//   clk_clk      system clock
//   reset_reset  asynchronous, active-high reset
//   buttons      [0]=mode [1]=inc [2]=dec [3]=dismiss (debounced, active-high)
//   alarm_en     alarm enable switch
//   hour_tens .. sec_units  registered BCD display digits
//   leds         ring pattern while ringing, else {alarm_en, 0000, one-hot mode}
//   ringing      alarm active
module alarm_clock_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int RING_SECS     = 60
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [3:0] buttons,
    input  logic       alarm_en,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_units,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [9:0] leds,
    output logic       ringing
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]    RING_LOAD = 8'(RING_SECS);

    localparam logic [2:0] MODE_RUN    = 3'd0;
    localparam logic [2:0] MODE_SET_H  = 3'd1;
    localparam logic [2:0] MODE_SET_M  = 3'd2;
    localparam logic [2:0] MODE_SET_AH = 3'd3;
    localparam logic [2:0] MODE_SET_AM = 3'd4;

    // Two-digit BCD increment, wrapping max_v -> 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD decrement, wrapping 00 -> max_v.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = max_v;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Apply an inc or dec event (at most one is set) to a BCD field.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] max_v,
                                            input logic inc, input logic dec);
        logic [7:0] r;
        if (inc) begin
            r = bcd_inc(v, max_v);
        end else if (dec) begin
            r = bcd_dec(v, max_v);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // One-hot mode indication for the status LEDs.
    function automatic logic [4:0] mode_onehot(input logic [2:0] m);
        logic [4:0] r;
        case (m)
            MODE_RUN:    r = 5'b00001;
            MODE_SET_H:  r = 5'b00010;
            MODE_SET_M:  r = 5'b00100;
            MODE_SET_AH: r = 5'b01000;
            MODE_SET_AM: r = 5'b10000;
            default:     r = 5'b00001;
        endcase
        return r;
    endfunction

    logic [PW-1:0] presc_r;
    logic [2:0]    mode_r;
    logic [7:0]    hh_r, mm_r, ss_r;
    logic [7:0]    al_hh_r, al_mm_r;
    logic [3:0]    btn_prev_r;
    logic          ring_r;
    logic [7:0]    ring_cnt_r;
    logic          ring_phase_r;
    logic [23:0]   digits_r;
    logic [9:0]    leds_r;

    logic [3:0]    rise_s;
    logic          ev_mode_s, ev_dismiss_s, ev_inc_s, ev_dec_s;
    logic          tick_s, counting_s, match_s;
    logic [PW-1:0] presc_nxt_s;
    logic [2:0]    mode_nxt_s;
    logic [7:0]    hh_nxt_s, mm_nxt_s, ss_nxt_s;
    logic [7:0]    al_hh_nxt_s, al_mm_nxt_s;
    logic          ring_nxt_s;
    logic [7:0]    ring_cnt_nxt_s;
    logic          ring_phase_nxt_s;
    logic [23:0]   digits_nxt_s;
    logic [9:0]    leds_nxt_s;

    // Button edge detection and event priority: mode > dismiss > inc > dec.
    always_comb begin
        rise_s       = buttons & ~btn_prev_r;
        ev_mode_s    = rise_s[0];
        ev_dismiss_s = rise_s[3] & ~rise_s[0];
        ev_inc_s     = rise_s[1] & ~rise_s[0] & ~rise_s[3];
        ev_dec_s     = rise_s[2] & ~rise_s[0] & ~rise_s[3] & ~rise_s[1];
        tick_s       = (presc_r == PRESC_MAX);
        // Time keeps running while the alarm is being edited, frozen while time is.
        counting_s   = (mode_r == MODE_RUN) || (mode_r == MODE_SET_AH) || (mode_r == MODE_SET_AM);
    end

    // Next-state for prescaler, time, alarm and mode.
    always_comb begin
        presc_nxt_s = tick_s ? {PW{1'b0}} : presc_r + PW'(1);
        hh_nxt_s    = hh_r;
        mm_nxt_s    = mm_r;
        ss_nxt_s    = ss_r;
        al_hh_nxt_s = al_hh_r;
        al_mm_nxt_s = al_mm_r;
        mode_nxt_s  = mode_r;

        if (tick_s && counting_s) begin
            ss_nxt_s = bcd_inc(ss_r, 8'h59);
            if (ss_r == 8'h59) begin
                mm_nxt_s = bcd_inc(mm_r, 8'h59);
                if (mm_r == 8'h59) begin
                    hh_nxt_s = bcd_inc(hh_r, 8'h23);
                end else begin
                    hh_nxt_s = hh_r;
                end
            end else begin
                mm_nxt_s = mm_r;
            end
        end else begin
            ss_nxt_s = ss_r;
        end

        case (mode_r)
            MODE_SET_H:  hh_nxt_s    = bcd_step(hh_r, 8'h23, ev_inc_s, ev_dec_s);
            MODE_SET_M:  mm_nxt_s    = bcd_step(mm_r, 8'h59, ev_inc_s, ev_dec_s);
            MODE_SET_AH: al_hh_nxt_s = bcd_step(al_hh_r, 8'h23, ev_inc_s, ev_dec_s);
            MODE_SET_AM: al_mm_nxt_s = bcd_step(al_mm_r, 8'h59, ev_inc_s, ev_dec_s);
            default:     al_mm_nxt_s = al_mm_r;
        endcase

        if (ev_mode_s) begin
            case (mode_r)
                MODE_RUN: begin
                    // Setting starts from a whole minute and a fresh second.
                    mode_nxt_s  = MODE_SET_H;
                    ss_nxt_s    = 8'h00;
                    presc_nxt_s = {PW{1'b0}};
                end
                MODE_SET_H:  mode_nxt_s = MODE_SET_M;
                MODE_SET_M: begin
                    // First second after the edit is a full one.
                    mode_nxt_s  = MODE_SET_AH;
                    presc_nxt_s = {PW{1'b0}};
                end
                MODE_SET_AH: mode_nxt_s = MODE_SET_AM;
                MODE_SET_AM: mode_nxt_s = MODE_RUN;
                default:     mode_nxt_s = MODE_RUN;
            endcase
        end else begin
            mode_nxt_s = mode_r;
        end
    end

    // Alarm match, ring sequencing and registered output values.
    always_comb begin
        match_s = tick_s && (mode_r == MODE_RUN) && !ev_mode_s && alarm_en &&
                  (ss_nxt_s == 8'h00) && (mm_nxt_s == al_mm_r) && (hh_nxt_s == al_hh_r);

        ring_nxt_s       = ring_r;
        ring_cnt_nxt_s   = ring_cnt_r;
        ring_phase_nxt_s = ring_phase_r;

        if (ring_r) begin
            if (ev_mode_s || ev_dismiss_s || !alarm_en) begin
                ring_nxt_s     = 1'b0;
                ring_cnt_nxt_s = 8'd0;
            end else if (tick_s) begin
                ring_phase_nxt_s = ~ring_phase_r;
                if (ring_cnt_r <= 8'd1) begin
                    ring_nxt_s     = 1'b0;
                    ring_cnt_nxt_s = 8'd0;
                end else begin
                    ring_cnt_nxt_s = ring_cnt_r - 8'd1;
                end
            end else begin
                ring_nxt_s = 1'b1;
            end
        end else if (match_s) begin
            // A match while already ringing lands in the branch above, so no reload.
            ring_nxt_s       = 1'b1;
            ring_cnt_nxt_s   = RING_LOAD;
            ring_phase_nxt_s = 1'b0;
        end else begin
            ring_nxt_s = 1'b0;
        end

        if (ring_nxt_s) begin
            leds_nxt_s = ring_phase_nxt_s ? 10'h000 : 10'h3FF;
        end else begin
            leds_nxt_s = {alarm_en, 4'b0000, mode_onehot(mode_nxt_s)};
        end

        if ((mode_r == MODE_SET_AH) || (mode_r == MODE_SET_AM)) begin
            digits_nxt_s = {al_hh_r, al_mm_r, 8'h00};
        end else begin
            digits_nxt_s = {hh_r, mm_r, ss_r};
        end
    end

    // State and output registers.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            presc_r      <= {PW{1'b0}};
            mode_r       <= MODE_RUN;
            hh_r         <= 8'h00;
            mm_r         <= 8'h00;
            ss_r         <= 8'h00;
            al_hh_r      <= 8'h00;
            al_mm_r      <= 8'h00;
            btn_prev_r   <= 4'b0000;
            ring_r       <= 1'b0;
            ring_cnt_r   <= 8'd0;
            ring_phase_r <= 1'b0;
            digits_r     <= 24'h000000;
            leds_r       <= 10'h001;
        end else begin
            presc_r      <= presc_nxt_s;
            mode_r       <= mode_nxt_s;
            hh_r         <= hh_nxt_s;
            mm_r         <= mm_nxt_s;
            ss_r         <= ss_nxt_s;
            al_hh_r      <= al_hh_nxt_s;
            al_mm_r      <= al_mm_nxt_s;
            btn_prev_r   <= buttons;
            ring_r       <= ring_nxt_s;
            ring_cnt_r   <= ring_cnt_nxt_s;
            ring_phase_r <= ring_phase_nxt_s;
            digits_r     <= digits_nxt_s;
            leds_r       <= leds_nxt_s;
        end
    end

    assign {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units} = digits_r;
    assign leds    = leds_r;
    assign ringing = ring_r;

endmodule
